// File: rtl/ad_bus_arbiter.sv
// Round-robin owner of the shared 32-bit ad bus; one tenure per grant,
// always followed by an undriven turnaround gap before the next grant.
module ad_bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MAX_HOLD    = 16,
  parameter int TURN_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     ad_drv_n,
  output logic                     timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int TW = 3;

  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);
  localparam logic [IW:0]   N_WIDE    = (IW+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] turn_q, turn_d;
  logic          tmo_q, tmo_d;

  logic          any_win;
  logic [IW-1:0] win;
  logic [IW:0]   sum;
  logic          rel;
  logic          expire;

  // Scan upward from the pointer, wrapping at N_REQ.
  always_comb begin
    any_win = 1'b0;
    win     = '0;
    sum     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= N_WIDE) sum = sum - N_WIDE;
      if (!any_win && req[sum[IW-1:0]]) begin
        any_win = 1'b1;
        win     = sum[IW-1:0];
      end
    end
  end

  assign rel    = done[own_q] | ~req[own_q];
  assign expire = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    tmo_d   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (any_win) begin
          state_d = GRANT;
          own_d   = win;
          hold_d  = HW'(1);
        end
      end
      (state_q == GRANT): begin
        if (rel || expire) begin
          state_d = TURN;
          ptr_d   = (own_q == LAST_IDX) ? '0 : own_q + IW'(1);
          turn_d  = TW'(1);
          // A real release wins over a coincident timeout.
          tmo_d   = expire && !rel;
        end else if (MAX_HOLD != 0 && hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
      end
      (state_q == TURN): begin
        if (turn_q == TURN_LAST) begin
          state_d = IDLE;
          own_d   = '0;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state_q == GRANT) gnt[own_q] = 1'b1;
    ad_drv_n = (state_q != GRANT);
    busy     = (state_q != IDLE);
    owner    = own_q;
    timeout  = tmo_q;
  end

endmodule

// File: doc/ad_bus_arbiter.md
# ad_bus_arbiter

Round-robin arbiter that shares the 32-bit `ad` tristate bus between up to `N_REQ` masters. Each master owns the bus for one tenure. A tenure ends on `done`, on request withdrawal, or on a hold-time timeout. A forced turnaround gap follows every tenure so no two `bufif0` driver banks overlap. The arbiter's active-low drive enable connects directly to the `bufif0` control pins of the bus driver array.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `MAX_HOLD`, 16: maximum tenure in cycles. 0 disables the timeout.
- `TURN_CYCLES`, 1: bus-undriven gap after each tenure, 1..7.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in `N_REQ`: level request, one bit per master.
- `done` in `N_REQ`: one-cycle release pulse from the owner.
- `gnt` out `N_REQ`: registered one-hot grant.
- `owner` out `$clog2(N_REQ)`: index of the granted master; 0 when idle.
- `busy` out 1: high in GRANT or TURN.
- `ad_drv_n` out 1: active-low bus drive enable. 0 only while `gnt` is non-zero.
- `timeout` out 1: one-cycle pulse when a tenure is revoked.

## Operation
State machine has three states: IDLE, GRANT, TURN.

Reset values (applied asynchronously while `reset_n`=0):
- `gnt`=0, `owner`=0, `busy`=0, `ad_drv_n`=1, `timeout`=0.
- Priority pointer = 0, hold counter = 0, turn counter = 0.

IDLE:
- If any `req` bit is high at a rising edge, the arbiter picks the first set bit scanning from the pointer upward, wrapping modulo `N_REQ`.
- At that edge: `gnt` = one-hot of the winner, `owner` = winner index, `ad_drv_n`=0, hold counter = 1, next state GRANT.
- If no `req` bit is high, the arbiter stays in IDLE.

GRANT:
- Release condition, sampled at each edge: `done[owner]`=1 or `req[owner]`=0. On release: `gnt`=0, `ad_drv_n`=1, pointer = (`owner`+1) mod `N_REQ`, next state TURN.
- Timeout condition: `MAX_HOLD`≠0, the hold counter equals `MAX_HOLD`, and there is no release. The arbiter releases as above and also drives `timeout`=1 for the next cycle only.
- Otherwise the hold counter increments and it saturates at `MAX_HOLD`. The counter width is `$clog2(MAX_HOLD+1)`, minimum 1.
- `done` bits from non-owners are ignored in every state.
- If `done[owner]` and the timeout condition occur at the same edge, it is a normal release and `timeout` stays 0.

TURN:
- Outputs during TURN: `gnt`=0, `ad_drv_n`=1, `busy`=1.
- TURN lasts exactly `TURN_CYCLES` cycles, then goes to IDLE.
- Requests seen during TURN are not acted on until IDLE.

`owner` keeps the last winner's index through TURN and reads 0 in IDLE.

`busy` = (state ≠ IDLE).

## Timing
- Grant latency: a `req` that is high at edge E while in IDLE gives `gnt` high in the cycle after E.
- Release latency: `done` sampled at edge E gives `gnt`=0 and `ad_drv_n`=1 in the cycle after E. There is no combinational path from `done` or `req` to any output.
- Minimum gap between two tenures is `TURN_CYCLES`+1 cycles with `gnt`=0 (TURN cycles plus one IDLE cycle).
- Longest tenure is exactly `MAX_HOLD` cycles with `gnt` high.
- `ad_drv_n` changes on the same edges as `gnt`. `ad_drv_n`=0 never overlaps a TURN cycle.
- `reset_n` asserted mid-tenure clears all outputs immediately, without waiting for `clk`. The first grant after release uses pointer 0.

## Test plan
1. Single requester: after reset, `req`=0010 is held and `done[1]` pulses 4 cycles after the grant.
   -> `gnt`=0010 and `ad_drv_n`=0 for 5 cycles.
   -> Then `gnt`=0 and `ad_drv_n`=1, with `busy` high for 1 TURN cycle.
2. Fairness: `req`=1111 held; each owner pulses `done` in its 2nd granted cycle.
   -> Grant order 0,1,2,3,0,1.
   -> Exactly 2 cycles with `gnt`=0 between tenures.
3. Timeout: `req`=0100 held with no `done`, `MAX_HOLD`=16, `req[3]` also held.
   -> `gnt[2]` high for exactly 16 cycles.
   -> `timeout` pulses 1 cycle.
   -> `gnt`=1000 follows 2 cycles later.
4. Collisions: `done[0]` pulses while master 1 owns the bus -> ignored. `done[1]` arrives on the 16th held cycle -> `timeout` stays 0.
5. Withdrawal: the owner drops `req` without `done` -> released exactly as if `done` had pulsed, and the pointer advances.
6. Reset mid-tenure: `reset_n`=0 while `gnt`=0100 -> `gnt`=0 and `ad_drv_n`=1 before the next `clk` edge. After release with `req`=1010 -> first `gnt`=0010.
